// File: rtl/scan_mux_if.sv
// Channel-bus interface for scan_mux: the packed channel inputs, select controls and registered outputs.
// data_par is present only when MUX_SCAN_PARITY_EN is defined.
interface scan_mux_if #(
  parameter int WIDTH    = 8,
  parameter int CHANNELS = 4,
  parameter int SEL_W    = 3
);
  logic [CHANNELS*WIDTH-1:0] data_in;
  logic [SEL_W-1:0]          sel;
  logic                      load_sel;
  logic                      scan_en;
  logic [WIDTH-1:0]          data_out;
  logic [SEL_W-1:0]          cur_sel;
  logic                      out_valid;
  logic                      sel_err;
`ifdef MUX_SCAN_PARITY_EN
  logic                      data_par;
`endif

  modport master (
    output data_in, sel, load_sel, scan_en,
    input  data_out, cur_sel, out_valid, sel_err
`ifdef MUX_SCAN_PARITY_EN
    , input data_par
`endif
  );

  modport slave (
    input  data_in, sel, load_sel, scan_en,
    output data_out, cur_sel, out_valid, sel_err
`ifdef MUX_SCAN_PARITY_EN
    , output data_par
`endif
  );
endinterface

// File: rtl/scan_mux.sv
// scan_mux: registered N-channel output selector with software load and timed auto-scan rotation.
// Defining MUX_SCAN_PARITY_EN adds a registered even-parity bit (data_par) for data_out.
module scan_mux #(
  parameter int WIDTH    = 8,
  parameter int CHANNELS = 4,
  parameter int SEL_W    = 3,
  parameter int DWELL    = 4
) (
  input  logic      clk,
  input  logic      rst_n,
  scan_mux_if.slave bus
);
  localparam int               CNT_W    = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam logic [SEL_W:0]   CH_LIM   = (SEL_W+1)'(CHANNELS);
  localparam logic [SEL_W-1:0] SEL_LAST = SEL_W'(CHANNELS - 1);
  localparam logic [SEL_W-1:0] SEL_ONE  = SEL_W'(1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DWELL - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic {ST_MANUAL = 1'b0, ST_SCAN = 1'b1} state_t;

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [SEL_W-1:0] r_cur_sel;
  logic [WIDTH-1:0] r_data_out;
  logic             r_out_valid;
  logic             r_sel_err;

  logic             w_sel_ok;
  logic             w_load_ok;
  logic             w_load_bad;
  logic             w_mode_chg;
  logic             w_step;
  logic             w_adv;
  logic [SEL_W-1:0] w_next_sel;
  logic [CNT_W-1:0] w_next_cnt;
  logic [WIDTH-1:0] w_data;

  function automatic logic even_par(input logic [WIDTH-1:0] v);
    return ^v;
  endfunction

  // Next selection and dwell count; an invalid load holds cur_sel but the dwell timer keeps running.
  always_comb begin
    w_sel_ok   = ({1'b0, bus.sel} < CH_LIM);
    w_load_ok  = bus.load_sel & w_sel_ok;
    w_load_bad = bus.load_sel & ~w_sel_ok;
    w_mode_chg = ((r_state == ST_SCAN) != bus.scan_en);
    w_step     = (r_state == ST_SCAN) && !w_mode_chg && !w_load_ok;
    w_adv      = w_step && (r_cnt == CNT_LAST) && !w_load_bad;

    if (w_load_ok) begin
      w_next_sel = bus.sel;
    end else if (w_adv) begin
      w_next_sel = (r_cur_sel == SEL_LAST) ? {SEL_W{1'b0}} : (r_cur_sel + SEL_ONE);
    end else begin
      w_next_sel = r_cur_sel;
    end

    if (w_load_ok || w_mode_chg) begin
      w_next_cnt = {CNT_W{1'b0}};
    end else if (w_step) begin
      w_next_cnt = (r_cnt == CNT_LAST) ? {CNT_W{1'b0}} : (r_cnt + CNT_ONE);
    end else begin
      w_next_cnt = r_cnt;
    end
  end

  // Channel mux on the selection that becomes current at this edge.
  always_comb begin
    w_data = {WIDTH{1'b0}};
    for (int k = 0; k < CHANNELS; k++) begin
      if (w_next_sel == SEL_W'(k)) begin
        w_data = bus.data_in[k*WIDTH +: WIDTH];
      end else begin
        w_data = w_data;
      end
    end
  end

  // Mode FSM plus all registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_MANUAL;
      r_cnt       <= {CNT_W{1'b0}};
      r_cur_sel   <= {SEL_W{1'b0}};
      r_data_out  <= {WIDTH{1'b0}};
      r_out_valid <= 1'b0;
      r_sel_err   <= 1'b0;
    end else begin
      case (r_state)
        ST_MANUAL: r_state <= bus.scan_en ? ST_SCAN : ST_MANUAL;
        ST_SCAN:   r_state <= bus.scan_en ? ST_SCAN : ST_MANUAL;
        default:   r_state <= ST_MANUAL;
      endcase
      r_cnt       <= w_next_cnt;
      r_cur_sel   <= w_next_sel;
      r_data_out  <= w_data;
      r_out_valid <= w_load_ok | w_adv;
      if (w_load_ok) begin
        r_sel_err <= 1'b0;
      end else if (w_load_bad) begin
        r_sel_err <= 1'b1;
      end else begin
        r_sel_err <= r_sel_err;
      end
    end
  end

`ifdef MUX_SCAN_PARITY_EN
  logic r_data_par;

  // Parity of the value entering data_out, aligned with it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_data_par <= 1'b0;
    end else begin
      r_data_par <= even_par(w_data);
    end
  end

  assign bus.data_par = r_data_par;
`endif

  assign bus.data_out  = r_data_out;
  assign bus.cur_sel   = r_cur_sel;
  assign bus.out_valid = r_out_valid;
  assign bus.sel_err   = r_sel_err;
endmodule
